// File: rtl/knap_pkg.sv
// ----------------------------------------------------------------------------
// knap_pkg
// Shared definitions for the knapsack stream evaluator:
//   - default parameter values
//   - FSM state encoding
//   - sat_add(): saturating add of a zero-extended coefficient into an
//     accumulator of runtime-selected width, reporting whether it clamped
// ----------------------------------------------------------------------------
package knap_pkg;

  localparam int DEF_N_ITEMS = 14;
  localparam int DEF_N_COST  = 2;
  localparam int DEF_COEF_W  = 8;
  localparam int DEF_ACC_W   = 12;

  // Working width of sat_add; accumulators must be narrower than this.
  localparam int SAT_W = 48;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // acc and coef arrive zero-extended to SAT_W; the result is clamped to
  // 2**acc_w-1. acc never exceeds that limit, so the SAT_W+1 bit sum cannot wrap.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] acc,
                                       input logic [SAT_W-1:0] coef,
                                       input int unsigned      acc_w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sat_res_t       res;
    sum     = {1'b0, acc} + {1'b0, coef};
    lim     = ((SAT_W+1)'(1) << acc_w) - (SAT_W+1)'(1);
    res.sat = (sum > lim);
    res.sum = res.sat ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/knap_sat_acc.sv
// ----------------------------------------------------------------------------
// knap_sat_acc
// One saturating accumulator with a sticky clamp flag.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_clr      clear sum and sticky flag (start of an evaluation)
//   i_en       add i_coef into the sum this cycle
//   i_coef     COEF_W coefficient, zero-extended before the add
//   o_sum      ACC_W saturated running sum
//   o_sat      set once any add has clamped since the last clear
// ----------------------------------------------------------------------------
module knap_sat_acc
  import knap_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [COEF_W-1:0] i_coef,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  logic [ACC_W-1:0]       r_sum;
  logic                   r_sat;
  sat_res_t               w_res;
  logic [SAT_W-ACC_W-1:0] w_unused_hi;

  assign w_res       = sat_add(SAT_W'(r_sum), SAT_W'(i_coef), ACC_W);
  // Always zero: the clamp keeps the result within ACC_W bits.
  assign w_unused_hi = w_res.sum[SAT_W-1:ACC_W];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sum <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_sum <= w_res.sum[ACC_W-1:0];
      r_sat <= r_sat | w_res.sat;
    end
  end

  assign o_sum = r_sum;
  assign o_sat = r_sat;

endmodule

// File: rtl/knap_stream_eval.sv
// ----------------------------------------------------------------------------
// knap_stream_eval
// Streams N_ITEMS candidate items, accumulates the value and N_COST costs of
// the selected ones with saturation, then reports totals and feasibility.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       begin an evaluation (IDLE only)
//   min_value, max_cost         thresholds, latched on an accepted start
//   item_valid/item_ready       item beat handshake (ready only in ACCUM)
//   item_sel                    1 = add this item, 0 = skip (still counted)
//   item_value, item_cost       item coefficients, cost dim d at [d*COEF_W +: COEF_W]
//   busy                        state != IDLE
//   res_valid/res_ready         result handshake (valid only in DONE)
//   res_feasible                value>=min, each cost<=cap, no cost clamped
//   res_value, res_cost, res_sat  saturated totals and any-clamp flag
// ----------------------------------------------------------------------------
module knap_stream_eval
  import knap_pkg::*;
#(
  parameter int N_ITEMS = DEF_N_ITEMS,
  parameter int N_COST  = DEF_N_COST,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ACC_W-1:0]         min_value,
  input  logic [N_COST*ACC_W-1:0]  max_cost,
  input  logic                     item_valid,
  output logic                     item_ready,
  input  logic                     item_sel,
  input  logic [COEF_W-1:0]        item_value,
  input  logic [N_COST*COEF_W-1:0] item_cost,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_feasible,
  output logic [ACC_W-1:0]         res_value,
  output logic [N_COST*ACC_W-1:0]  res_cost,
  output logic                     res_sat
);

  localparam int CNT_W = $clog2(N_ITEMS + 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CNT_W-1:0]          r_count;
  logic [ACC_W-1:0]          r_min;
  logic [N_COST*ACC_W-1:0]   r_cap;

  logic                      w_start_ok;
  logic                      w_accept;
  logic                      w_add;
  logic                      w_last;
  logic [ACC_W-1:0]          w_sum [N_COST+1];
  logic [N_COST:0]           w_sat;
  logic [N_COST-1:0]         w_cost_ok;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_accept   = (r_state == S_ACCUM) && item_valid;
  assign w_add      = w_accept && item_sel;
  assign w_last     = w_accept && (r_count == CNT_W'(N_ITEMS - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    item_ready   = 1'b0;
    res_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        item_ready = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        // A start arriving in this cycle is seen by IDLE logic only next cycle.
        if (res_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- beat counter and thresholds ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_min   <= '0;
      r_cap   <= '0;
    end else if (w_start_ok) begin
      r_count <= '0;
      r_min   <= min_value;
      r_cap   <= max_cost;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // ---------------- accumulators: [0] value, [1..N_COST] costs ----------------
  for (genvar g = 0; g <= N_COST; g++) begin : g_acc
    logic [COEF_W-1:0] w_coef;
    if (g == 0) begin : g_val
      assign w_coef = item_value;
    end else begin : g_cost
      assign w_coef = item_cost[(g-1)*COEF_W +: COEF_W];
    end

    knap_sat_acc #(
      .ACC_W  (ACC_W),
      .COEF_W (COEF_W)
    ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_start_ok),
      .i_en   (w_add),
      .i_coef (w_coef),
      .o_sum  (w_sum[g]),
      .o_sat  (w_sat[g])
    );
  end

  // ---------------- result ----------------
  for (genvar d = 0; d < N_COST; d++) begin : g_cmp
    assign res_cost[d*ACC_W +: ACC_W] = w_sum[d+1];
    // A clamped cost may read exactly equal to the cap, so the flag is checked too.
    assign w_cost_ok[d] = (w_sum[d+1] <= r_cap[d*ACC_W +: ACC_W]) && !w_sat[d+1];
  end

  assign res_value    = w_sum[0];
  assign res_sat      = |w_sat;
  // Value saturation alone does not make a selection infeasible.
  assign res_feasible = (r_state == S_DONE) && (w_sum[0] >= r_min) && (&w_cost_ok);

endmodule

// File: tb/tb_knap_stream_eval.sv
// ----------------------------------------------------------------------------
// tb_knap_stream_eval
// Two evaluators (ACC_W=12 and ACC_W=8) share one item stream. A bench-side
// model tracks phase and raw unbounded sums; expected totals are the sums
// clamped to each accumulator's range.
// ----------------------------------------------------------------------------
module tb_knap_stream_eval;

  localparam int N = 14;

  logic        clk = 1'b0;
  logic        rst, start, item_valid, item_sel, res_ready;
  logic [7:0]  item_value;
  logic [15:0] item_cost;
  logic [11:0] min12;
  logic [23:0] cap12;
  logic [7:0]  min8;
  logic [15:0] cap8;

  logic        r12_ready, r12_busy, r12_valid, r12_feas, r12_sat;
  logic [11:0] r12_value;
  logic [23:0] r12_cost;
  logic        r8_ready, r8_busy, r8_valid, r8_feas, r8_sat;
  logic [7:0]  r8_value;
  logic [15:0] r8_cost;

  always #5 clk = ~clk;

  knap_stream_eval #(.N_ITEMS(N), .N_COST(2), .COEF_W(8), .ACC_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(start), .min_value(min12), .max_cost(cap12),
    .item_valid(item_valid), .item_ready(r12_ready), .item_sel(item_sel),
    .item_value(item_value), .item_cost(item_cost), .busy(r12_busy),
    .res_valid(r12_valid), .res_ready(res_ready), .res_feasible(r12_feas),
    .res_value(r12_value), .res_cost(r12_cost), .res_sat(r12_sat)
  );

  knap_stream_eval #(.N_ITEMS(N), .N_COST(2), .COEF_W(8), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .min_value(min8), .max_cost(cap8),
    .item_valid(item_valid), .item_ready(r8_ready), .item_sel(item_sel),
    .item_value(item_value), .item_cost(item_cost), .busy(r8_busy),
    .res_valid(r8_valid), .res_ready(res_ready), .res_feasible(r8_feas),
    .res_value(r8_value), .res_cost(r8_cost), .res_sat(r8_sat)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting items, 2 result offered
  int m_phase = 0;
  int m_count = 0;
  bit m_fresh = 1'b1;
  int m_min [2];
  int m_cap [2][2];
  int m_sv  [2];
  int m_sc  [2][2];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_count = 0; m_fresh = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_min[k] = 0; m_sv[k] = 0;
        for (int d = 0; d < 2; d++) begin m_cap[k][d] = 0; m_sc[k][d] = 0; end
      end
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_count = 0; m_fresh = 1'b0;
          m_min[0] = int'(min12); m_cap[0][0] = int'(cap12[11:0]); m_cap[0][1] = int'(cap12[23:12]);
          m_min[1] = int'(min8);  m_cap[1][0] = int'(cap8[7:0]);   m_cap[1][1] = int'(cap8[15:8]);
          for (int k = 0; k < 2; k++) begin m_sv[k] = 0; m_sc[k][0] = 0; m_sc[k][1] = 0; end
        end
        1: if (item_valid) begin
          m_count++;
          if (item_sel) for (int k = 0; k < 2; k++) begin
            m_sv[k]    += int'(item_value);
            m_sc[k][0] += int'(item_cost[7:0]);
            m_sc[k][1] += int'(item_cost[15:8]);
          end
          if (m_count == N) m_phase = 2;
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  task automatic check_dut(input int k, input logic rdy, input logic bsy, input logic vld,
                           input logic feas, input logic sat,
                           input logic [11:0] val, input logic [11:0] c0, input logic [11:0] c1);
    int mx, ev, e0, e1;
    bit es, ef;
    mx = (k == 0) ? 4095 : 255;
    ev = (m_sv[k]    > mx) ? mx : m_sv[k];
    e0 = (m_sc[k][0] > mx) ? mx : m_sc[k][0];
    e1 = (m_sc[k][1] > mx) ? mx : m_sc[k][1];
    es = (m_sv[k] > mx) || (m_sc[k][0] > mx) || (m_sc[k][1] > mx);
    ef = (m_phase == 2) && (ev >= m_min[k]) && (m_sc[k][0] <= mx) && (m_sc[k][1] <= mx)
         && (e0 <= m_cap[k][0]) && (e1 <= m_cap[k][1]);
    check($sformatf("d%0d_item_ready", k), longint'(rdy), longint'(m_phase == 1));
    check($sformatf("d%0d_busy", k),       longint'(bsy), longint'(m_phase != 0));
    check($sformatf("d%0d_res_valid", k),  longint'(vld), longint'(m_phase == 2));
    check($sformatf("d%0d_res_feasible", k), longint'(feas), longint'(ef));
    if (m_phase == 2 || m_fresh) begin
      check($sformatf("d%0d_res_value", k), longint'(val), longint'(ev));
      check($sformatf("d%0d_res_cost0", k), longint'(c0),  longint'(e0));
      check($sformatf("d%0d_res_cost1", k), longint'(c1),  longint'(e1));
      check($sformatf("d%0d_res_sat", k),   longint'(sat), longint'(es));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, r12_ready, r12_busy, r12_valid, r12_feas, r12_sat,
                r12_value, r12_cost[11:0], r12_cost[23:12]);
      check_dut(1, r8_ready, r8_busy, r8_valid, r8_feas, r8_sat,
                {4'd0, r8_value}, {4'd0, r8_cost[7:0]}, {4'd0, r8_cost[15:8]});
    end
  end

  // ---------------- stimulus ----------------
  int s_sel [N];
  int s_val [N];
  int s_c0  [N];
  int s_c1  [N];

  // Snapshot of the result on the first DONE cycle, for hand-computed checks.
  int g_val, g_c0, g_c1, g_feas, g_sat, g8_val, g8_c0, g8_feas, g8_sat;

  task automatic set_thr(input int mn12, input int c12, input int mn8, input int c8);
    min12 = 12'(mn12); cap12 = {12'(c12), 12'(c12)};
    min8  = 8'(mn8);   cap8  = {8'(c8), 8'(c8)};
  endtask

  task automatic run_eval(input int n_beats, input bit bp, input int hold);
    int idx, cyc;
    bit acc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < n_beats && cyc < 400) begin
      item_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      item_sel   = 1'(s_sel[idx]);
      item_value = 8'(s_val[idx]);
      item_cost  = {8'(s_c1[idx]), 8'(s_c0[idx])};
      acc = item_valid && r12_ready;
      @(negedge clk); cyc++;
      if (acc) idx++;
    end
    item_valid = 1'b0;
    if (idx < n_beats) begin
      check("beat_budget", idx, n_beats);
      return;
    end
    if (n_beats < N) return;
    // One cycle after the last accepted beat the result must be offered.
    check("latency_res_valid", longint'(r12_valid), 1);
    g_val = int'(r12_value); g_c0 = int'(r12_cost[11:0]); g_c1 = int'(r12_cost[23:12]);
    g_feas = int'(r12_feas); g_sat = int'(r12_sat);
    g8_val = int'(r8_value); g8_c0 = int'(r8_cost[7:0]); g8_feas = int'(r8_feas); g8_sat = int'(r8_sat);
    // Extra beats and start pulses while the result waits must be ignored.
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      item_valid = 1'b1; item_sel = 1'b1;
      item_value = 8'($urandom_range(1, 255)); item_cost = 16'($urandom_range(1, 65535));
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    item_valid = 1'b0;
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0;
    check("start_in_handshake_ignored", longint'(r12_busy), 0);
    @(negedge clk);
  endtask

  task automatic load_uniform(input int odd_only, input int v, input int c0, input int c1);
    for (int i = 0; i < N; i++) begin
      s_sel[i] = odd_only ? (i % 2) : 1;
      s_val[i] = v; s_c0[i] = c0; s_c1[i] = c1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; item_valid = 1'b0; item_sel = 1'b0; res_ready = 1'b0;
    item_value = '0; item_cost = '0;
    set_thr(0, 0, 0, 0);
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", longint'(r12_busy), 0);
    check("reset_value", longint'(r12_value), 0);
    rst = 1'b0;

    // Test 1: 14 x (value 10, costs 4), min 120, caps 60.
    load_uniform(0, 10, 4, 4);
    set_thr(120, 60, 120, 60);
    run_eval(N, 1'b0, 1);
    check("t1_value", g_val, 140);
    check("t1_cost0", g_c0, 56);
    check("t1_cost1", g_c1, 56);
    check("t1_feasible", g_feas, 1);
    check("t1_acc8_value", g8_val, 140);

    // Test 2: same stream, min 141.
    set_thr(141, 60, 141, 60);
    run_eval(N, 1'b0, 2);
    check("t2_feasible", g_feas, 0);
    check("t2_value", g_val, 140);
    check("t2_sat", g_sat, 0);

    // Test 3: odd items only, value 20, cost0 9, cost1 0.
    load_uniform(1, 20, 9, 0);
    set_thr(120, 60, 120, 60);
    run_eval(N, 1'b0, 0);
    check("t3_value", g_val, 140);
    check("t3_cost0", g_c0, 63);
    check("t3_feasible", g_feas, 0);

    // Test 4: two beats of cost0=200 clamp the 8-bit accumulator.
    load_uniform(0, 1, 0, 0);
    s_val[0] = 5; s_c0[0] = 200;
    s_val[5] = 5; s_c0[5] = 200;
    set_thr(0, 500, 0, 255);
    run_eval(N, 1'b0, 1);
    check("t4_acc8_cost0", g8_c0, 255);
    check("t4_acc8_sat", g8_sat, 1);
    check("t4_acc8_feasible", g8_feas, 0);
    check("t4_acc12_cost0", g_c0, 400);
    check("t4_acc12_feasible", g_feas, 1);

    // Test 5: random item_valid, result held 5 cycles with start pulses.
    load_uniform(0, 10, 4, 4);
    set_thr(120, 60, 120, 60);
    run_eval(N, 1'b1, 5);
    check("t5_value", g_val, 140);
    check("t5_feasible", g_feas, 1);

    // Test 6: reset after 7 beats, then the test-1 stream again.
    run_eval(7, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", longint'(r12_busy), 0);
    check("t6_item_ready", longint'(r12_ready), 0);
    check("t6_value", longint'(r12_value), 0);
    check("t6_cost", longint'(r12_cost), 0);
    rst = 1'b0;
    run_eval(N, 1'b0, 1);
    check("t6_rerun_value", g_val, 140);
    check("t6_rerun_feasible", g_feas, 1);

    // Random streams and thresholds.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) begin
        s_sel[i] = int'($urandom_range(0, 1));
        s_val[i] = int'($urandom_range(0, 255));
        s_c0[i]  = int'($urandom_range(0, 255));
        s_c1[i]  = int'($urandom_range(0, 255));
      end
      min12 = 12'($urandom_range(0, 2000));
      cap12 = {12'($urandom_range(0, 2000)), 12'($urandom_range(0, 2000))};
      min8  = 8'($urandom_range(0, 255));
      cap8  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      run_eval(N, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
